seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 155 +++++++++++++++
 tb/tb_seq_div.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, signed or unsigned, one quotient bit per cycle.
// Fixed latency: the start edge, then WIDTH CALC steps, one FIX cycle and one DONE cycle.
// Optional feature macro: DIV_ZERO_DETECT_EN.
// When it is defined, a zero divisor skips the iteration and completes immediately.
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // settled partial remainder (always < divisor magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz_q, dz_d;
`endif

  logic             accept;
  logic             dd_neg, dv_neg;
  logic [WIDTH:0]   rem_sh;           // WIDTH+1-bit partial remainder after the shift
  logic [WIDTH:0]   diff;

  // Two's-complement negate when neg is set; the most-negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Next-state, iteration step and result formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif

    accept = start && ((state_q == IDLE) || (state_q == DONE));
    dd_neg = is_signed & dividend[WIDTH-1];
    dv_neg = is_signed & divisor[WIDTH-1];
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          q_neg_d = dd_neg ^ dv_neg;
          r_neg_d = dd_neg;
          quo_d   = cond_neg(dividend, dd_neg);
          dvs_d   = cond_neg(divisor, dv_neg);
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        // A clear top bit means the trial subtraction did not borrow.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        q_d     = cond_neg(quo_q, q_neg_q);
        r_d     = cond_neg(rem_q, r_neg_q);
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = 1'b0;
`endif
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and visible results; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // Iteration datapath; always reloaded on an accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dvs_q   <= dvs_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed corner cases plus randomized vectors for seq_div.
// Two instances are used: WIDTH=32 and WIDTH=8.
module tb_seq_div;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, st32, sg32;
  logic [31:0] dd32, dv32, q32, r32;
  logic        bz32, dn32, dz32;

  logic        rst8, st8, sg8;
  logic [7:0]  dd8, dv8, q8, r8;
  logic        bz8, dn8, dz8;

  int n_vec = 0;
  int n_err = 0;

  seq_div #(.WIDTH(32)) u_div32 (
    .clk(clk), .reset(rst32), .start(st32), .is_signed(sg32),
    .dividend(dd32), .divisor(dv32), .q(q32), .r(r32),
    .busy(bz32), .done(dn32), .div_zero(dz32)
  );

  seq_div #(.WIDTH(8)) u_div8 (
    .clk(clk), .reset(rst8), .start(st8), .is_signed(sg8),
    .dividend(dd8), .divisor(dv8), .q(q8), .r(r8),
    .busy(bz8), .done(dn8), .div_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on sign- or zero-extended 64-bit values.
  // SystemVerilog '/' truncates toward zero and '%' takes the dividend's sign.
  function automatic void model(input int w, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] qe,
                                output logic [31:0] re);
    longint sa, sb, sq, sr;
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    if (sgn && w == 32) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else if (sgn) begin
      sa = longint'($signed(a[7:0]));
      sb = longint'($signed(b[7:0]));
    end else begin
      sa = longint'({32'b0, a & m});
      sb = longint'({32'b0, b & m});
    end
    sq = sa / sb;
    sr = sa % sb;
    qe = sq[31:0] & m;
    re = sr[31:0] & m;
  endfunction

  // Drive a start for one cycle; returns #1 after the start edge.
  task automatic launch(input bit w8, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      st8 = 1'b1; sg8 = sgn; dd8 = a[7:0]; dv8 = b[7:0];
    end else begin
      st32 = 1'b1; sg32 = sgn; dd32 = a; dv32 = b;
    end
    @(posedge clk); #1;
    st8  = 1'b0;
    st32 = 1'b0;
  endtask

  // Count edges from the start edge until done is seen, and busy cycles on the way.
  task automatic wait_done(input bit w8, input string tag, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!(w8 ? dn8 : dn32) && lat < 200) begin
      if (w8 ? bz8 : bz32) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!(w8 ? dn8 : dn32)) check({tag, ".done_seen"}, 64'(w8 ? dn8 : dn32), 64'd1);
  endtask

  task automatic check_result(input bit w8, input string tag, input logic [31:0] eq,
                              input logic [31:0] er, input logic edz);
    logic [31:0] qo, ro;
    logic        dzo;
    qo  = w8 ? {24'b0, q8} : q32;
    ro  = w8 ? {24'b0, r8} : r32;
    dzo = w8 ? dz8 : dz32;
    check({tag, ".q"}, 64'(qo), 64'(eq));
    check({tag, ".r"}, 64'(ro), 64'(er));
    check({tag, ".div_zero"}, 64'(dzo), 64'(edz));
  endtask

  task automatic run_div(input bit w8, input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat);
    int lat, nb;
    launch(w8, sgn, a, b);
    wait_done(w8, tag, lat, nb);
    check_result(w8, tag, eq, er, edz);
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check({tag, ".busy_cycles"}, 64'(nb), 64'(elat));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(w8 ? dn8 : dn32), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, ndone;
    logic [31:0] a, b, eq, er;
    logic sgn;

    rst32 = 1'b1; st32 = 1'b0; sg32 = 1'b0; dd32 = '0; dv32 = '0;
    rst8  = 1'b1; st8  = 1'b0; sg8  = 1'b0; dd8  = '0; dv8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst32.q",    64'(q32),  64'd0);
    check("rst32.r",    64'(r32),  64'd0);
    check("rst32.busy", 64'(bz32), 64'd0);
    check("rst32.done", 64'(dn32), 64'd0);
    check("rst32.dz",   64'(dz32), 64'd0);
    check("rst8.q",     64'(q8),   64'd0);
    check("rst8.r",     64'(r8),   64'd0);
    rst32 = 1'b0;
    rst8  = 1'b0;

    // Basic unsigned: done WIDTH+1 edges after start, busy through CALC and FIX.
    run_div(0, "u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    // Signed truncation toward zero, remainder follows the dividend.
    run_div(0, "s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div(0, "s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    // Most-negative / -1 signed, and the same bits unsigned.
    run_div(0, "s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_div(0, "u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);

    // Divide by zero, unsigned.
`ifdef DIV_ZERO_DETECT_EN
    run_div(0, "dz", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0);
    // A later normal division clears div_zero.
    run_div(0, "dz_clr", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);
`else
    run_div(0, "dz", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b0, 33);
`endif

    // Second start while busy and operand churn have no effect.
    st32 = 1'b1; sg32 = 1'b0; dd32 = 32'd1000; dv32 = 32'd3;
    @(posedge clk); #1;
    st32 = 1'b0;
    lat = 0;
    while (!dn32 && lat < 200) begin
      dd32 = $urandom;
      dv32 = $urandom;
      sg32 = 1'($urandom_range(0, 1));
      st32 = (lat == 4);
      @(posedge clk); #1;
      lat++;
    end
    st32 = 1'b0;
    sg32 = 1'b0;
    check("ignore.done_seen", 64'(dn32), 64'd1);
    check_result(0, "ignore", 32'd333, 32'd1, 1'b0);
    check("ignore.latency", 64'(lat), 64'd33);
    @(posedge clk); #1;
    check("ignore.done_pulse", 64'(dn32), 64'd0);

    // Start accepted in the DONE cycle runs back-to-back.
    launch(0, 1'b0, 32'd12345, 32'd67);
    wait_done(0, "chain1", lat, nb);
    check_result(0, "chain1", 32'd184, 32'd17, 1'b0);
    launch(0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    check("chain2.busy", 64'(bz32), 64'd1);
    wait_done(0, "chain2", lat, nb);
    check_result(0, "chain2", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    check("chain2.latency", 64'(lat), 64'd33);
    @(posedge clk); #1;

    // Reset wins over a simultaneous start.
    rst32 = 1'b1; st32 = 1'b1; dd32 = 32'd9; dv32 = 32'd2;
    @(posedge clk); #1;
    rst32 = 1'b0; st32 = 1'b0;
    check("rst_prio.busy", 64'(bz32), 64'd0);
    check("rst_prio.q", 64'(q32), 64'd0);
    @(posedge clk); #1;
    check("rst_prio.busy2", 64'(bz32), 64'd0);

    // Randomized WIDTH=32.
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = ~b + 32'd1;
      if (b == 32'd0) b = 32'd1;
      model(32, sgn, a, b, eq, er);
      run_div(0, "rnd32", sgn, a, b, eq, er, 1'b0, 33);
    end

    // WIDTH=8: a completed division, then reset mid-operation, then a fresh one.
    run_div(1, "u8_pre", 1'b0, 32'd255, 32'd4, 32'd63, 32'd3, 1'b0, 9);
    launch(1, 1'b0, 32'd77, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(bz8), 64'd1);
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    check("abort.q",    64'(q8),  64'd0);
    check("abort.r",    64'(r8),  64'd0);
    check("abort.busy", 64'(bz8), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (dn8) ndone++;
      @(posedge clk); #1;
    end
    check("abort.no_done", 64'(ndone), 64'd0);
    run_div(1, "u8_200_9", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 9);
    run_div(1, "s8_ovf", 1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 9);

    // Randomized WIDTH=8.
    for (int i = 0; i < 20; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 255));
      b = 32'($urandom_range(1, 255));
      model(8, sgn, a, b, eq, er);
      run_div(1, "rnd8", sgn, a, b, eq, er, 1'b0, 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
